tft_ctrl_pio: RTL and testbench

Parametrised Avalon-MM output PIO driving the TFT panel control strobes (nRD, nWR, RS, nCS, RESET) from the Nios II bus. It holds a WIDTH-bit output register with atomic set/clear access and a hardware pulse engine. The pulse engine inverts selected bits for exactly PULSE_CYCLES clocks, so firmware can strobe nRD/nWR at deterministic width without bit-banging. It sits in the same position as the single-bit control PIOs in the Qsys system, between the Avalon interconnect and the TFT connector pins.

---
 rtl/tft_ctrl_pio.sv | 141 ++++++++++++++
 tb/tb_tft_ctrl_pio.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tft_ctrl_pio.sv
// tft_ctrl_pio: Avalon-MM output PIO for the TFT panel control strobes.
// Holds a WIDTH-bit output register with atomic SET/CLR access.
// Optional pulse engine (enabled by defining TFT_PIO_PULSE_EN) inverts
// selected bits for exactly PULSE_CYCLES clocks and reports busy.
// Register map: 0 DATA, 1 SET, 2 CLR, 3 PULSE (write) / STATUS (read).
module tft_ctrl_pio #(
  parameter int unsigned      WIDTH        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '1,
  parameter int unsigned      PULSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
);

  localparam int unsigned CW = $clog2(PULSE_CYCLES + 1);

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic [31:0]      w_status;
  logic             w_unused_wd;

  assign w_wr        = chipselect && !write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  // Bits of writedata above WIDTH are intentionally ignored.
  assign w_unused_wd = ^writedata;

  // Next value of the data register from DATA/SET/CLR writes.
  always_comb begin
    w_data_nxt = r_data;
    if (w_wr) begin
      case (address)
        2'd0:    w_data_nxt = w_wd;
        2'd1:    w_data_nxt = r_data | w_wd;
        2'd2:    w_data_nxt = r_data & ~w_wd;
        default: w_data_nxt = r_data;
      endcase
    end
  end

  // Data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_data <= RESET_VALUE;
    else       r_data <= w_data_nxt;
  end

`ifdef TFT_PIO_PULSE_EN

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_mask_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_out;

  // Pulse engine next-state: arm on a non-zero PULSE write in IDLE only.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_mask_nxt = '0;
        if (w_wr && (address == 2'd3) && (w_wd != '0)) begin
          w_state_nxt = S_ACTIVE;
          w_mask_nxt  = w_wd;
          w_cnt_nxt   = CW'(PULSE_CYCLES - 1);
        end
      end
      S_ACTIVE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_mask_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mask_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pulse engine state, mask and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pin register built from next-state values so pins change at the capturing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_out <= RESET_VALUE;
    else       r_out <= w_data_nxt ^ ((w_state_nxt == S_ACTIVE) ? w_mask_nxt : '0);
  end

  assign busy     = (r_state == S_ACTIVE);
  assign out_port = r_out;
  assign w_status = {31'b0, busy};

`else

  assign busy     = 1'b0;
  assign out_port = r_data;
  assign w_status = '0;

`endif

  // Zero-wait-state read mux; chipselect is not qualified.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = 32'(r_data);
      2'd3:    readdata = w_status;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_tft_ctrl_pio.sv
// Directed self-checking bench for tft_ctrl_pio (WIDTH=4, RESET_VALUE=F, PULSE_CYCLES=3).
// Pulse-engine scenarios are built only when TFT_PIO_PULSE_EN is defined.
module tb_tft_ctrl_pio;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        busy;

  int unsigned n_checks;
  int unsigned n_errors;

  tft_ctrl_pio #(
    .WIDTH        (4),
    .RESET_VALUE  (4'hF),
    .PULSE_CYCLES (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a write in the low phase; return 1ns after the capturing edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  // Idle one clock; return 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational read with chipselect low.
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] v;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    #22;
    reset = 1'b0;

    // 1. asynchronous reset mid-cycle
    wr(2'd0, 32'h5);
    check("pre_reset_out", {28'h0, out_port}, 32'h5);
    #2;
    reset = 1'b1;
    #1;
    check("reset_out", {28'h0, out_port}, 32'hF);
    check("reset_busy", {31'h0, busy}, 32'h0);
    rd(2'd0, v);
    check("reset_rd0", v, 32'h0000000F);
    @(negedge clk);
    reset = 1'b0;

    // 2. set / clear
    wr(2'd0, 32'hFFFF_FFF5);
    check("data_out", {28'h0, out_port}, 32'h5);
    wr(2'd1, 32'h2);
    check("set_out", {28'h0, out_port}, 32'h7);
    wr(2'd2, 32'h4);
    check("clr_out", {28'h0, out_port}, 32'h3);
    rd(2'd0, v);
    check("sc_rd0", v, 32'h3);
    rd(2'd1, v);
    check("rd1_zero", v, 32'h0);
    rd(2'd2, v);
    check("rd2_zero", v, 32'h0);
    tick();
    check("hold_out", {28'h0, out_port}, 32'h3);

`ifdef TFT_PIO_PULSE_EN
    // 3. single pulse on bit 0
    wr(2'd0, 32'hF);
    wr(2'd3, 32'h1);
    check("p_e0_out", {28'h0, out_port}, 32'hE);
    check("p_e0_busy", {31'h0, busy}, 32'h1);
    rd(2'd3, v);
    check("p_rd3_busy", v, 32'h1);
    tick();
    check("p_e1_out", {28'h0, out_port}, 32'hE);
    tick();
    check("p_e2_out", {28'h0, out_port}, 32'hE);
    check("p_e2_busy", {31'h0, busy}, 32'h1);
    tick();
    check("p_e3_out", {28'h0, out_port}, 32'hF);
    check("p_e3_busy", {31'h0, busy}, 32'h0);
    rd(2'd3, v);
    check("p_rd3_idle", v, 32'h0);

    // 4. re-arm attempts during busy are ignored; first idle cycle accepted
    wr(2'd3, 32'h1);
    check("ra_e0_out", {28'h0, out_port}, 32'hE);
    tick();
    wr(2'd3, 32'h2);
    check("ra_e2_out", {28'h0, out_port}, 32'hE);
    wr(2'd3, 32'h2);
    check("ra_e3_out", {28'h0, out_port}, 32'hF);
    check("ra_e3_busy", {31'h0, busy}, 32'h0);
    wr(2'd3, 32'h2);
    check("ra2_e0_out", {28'h0, out_port}, 32'hD);
    check("ra2_e0_busy", {31'h0, busy}, 32'h1);
    tick();
    tick();
    check("ra2_e2_out", {28'h0, out_port}, 32'hD);
    tick();
    check("ra2_e3_out", {28'h0, out_port}, 32'hF);
    check("ra2_e3_busy", {31'h0, busy}, 32'h0);

    // 5. CLR during a pulse, then zero-mask pulse
    wr(2'd3, 32'h1);
    check("wp_e0_out", {28'h0, out_port}, 32'hE);
    tick();
    wr(2'd2, 32'h8);
    check("wp_e2_out", {28'h0, out_port}, 32'h6);
    tick();
    check("wp_e3_out", {28'h0, out_port}, 32'h7);
    check("wp_e3_busy", {31'h0, busy}, 32'h0);
    rd(2'd0, v);
    check("wp_rd0", v, 32'h7);
    wr(2'd3, 32'h0);
    check("zm_busy", {31'h0, busy}, 32'h0);
    check("zm_out", {28'h0, out_port}, 32'h7);

    // 6. reset in the second busy cycle aborts the pulse
    wr(2'd0, 32'h5);
    wr(2'd3, 32'h1);
    check("rp_e0_out", {28'h0, out_port}, 32'h4);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rp_out", {28'h0, out_port}, 32'hF);
    check("rp_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("rp_after_out", {28'h0, out_port}, 32'hF);
    check("rp_after_busy", {31'h0, busy}, 32'h0);
`else
    // 6b. pulse engine absent: addr 3 writes ignored, reads 0
    wr(2'd0, 32'h5);
    wr(2'd3, 32'h1);
    check("np_out", {28'h0, out_port}, 32'h5);
    check("np_busy", {31'h0, busy}, 32'h0);
    rd(2'd3, v);
    check("np_rd3", v, 32'h0);
    tick();
    check("np_out_later", {28'h0, out_port}, 32'h5);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
